// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the ordered reset-release sequencer.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STRETCH,
        RELEASE,
        RUN
    } seq_state_t;

    // One width fits every timer, so the widest terminal count sets the size.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// Button conditioning: multi-flop synchroniser followed by a level debouncer.
module sync_debounce
    import reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 650000,
    parameter int CNT_W        = cnt_width(DEBOUNCE_CYC, 1, 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0] db_cnt;
    logic             din_s;

    assign din_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            db_cnt <= '0;
            dout   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            // Any reversal back to the accepted level restarts the stability window.
            if (din_s == dout) begin
                db_cnt <= '0;
            end else if (db_cnt >= CNT_W'(DEBOUNCE_CYC - 1)) begin
                dout   <= din_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Releases N_CH active-high resets in order once the clock generator is locked.
//   state     | meaning
//   WAIT_LOCK | all resets held; waiting for lock with button released
//   STRETCH   | lock seen; holding for STRETCH_CYC before first release
//   RELEASE   | releasing one channel every GAP_CYC cycles
//   RUN       | every channel released, ready high
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int STRETCH_CYC  = 1024,
    parameter int GAP_CYC      = 64,
    parameter int DEBOUNCE_CYC = 650000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      locked,
    input  logic                      btn,
    output logic [N_CH-1:0]           rst_out,
    output logic                      ready,
    output logic [$clog2(N_CH+1)-1:0] stage
);

    localparam int CNT_W = cnt_width(STRETCH_CYC, GAP_CYC, DEBOUNCE_CYC);
    localparam int STG_W = $clog2(N_CH + 1);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] locked_sync;
    logic             locked_s;
    logic             btn_db;
    logic             abort;
    seq_state_t       state;
    logic [CNT_W-1:0] cnt;

    sync_debounce #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W)
    ) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (btn),
        .dout  (btn_db)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) locked_sync <= '0;
        else        locked_sync <= {locked_sync[SYNC_STAGES-2:0], locked};
    end

    assign locked_s = locked_sync[SYNC_STAGES-1];
    assign abort    = !locked_s || btn_db;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            rst_out <= '1;
            ready   <= 1'b0;
            stage   <= '0;
        end else if (abort) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            rst_out <= '1;
            ready   <= 1'b0;
            stage   <= '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    state <= STRETCH;
                    cnt   <= CNT_W'(STRETCH_CYC - 1);
                end
                STRETCH: begin
                    if (cnt == '0) begin
                        rst_out <= rst_out << 1;
                        stage   <= STG_W'(1);
                        if (N_CH == 1) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end else begin
                            state <= RELEASE;
                            cnt   <= CNT_W'(GAP_CYC - 1);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    // Channels release bit 0 upward, so a left shift drops the next one.
                    if (cnt == '0) begin
                        rst_out <= rst_out << 1;
                        stage   <= stage + 1'b1;
                        if (stage == STG_W'(N_CH - 1)) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end else begin
                            cnt <= CNT_W'(GAP_CYC - 1);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state   <= WAIT_LOCK;
                    cnt     <= '0;
                    rst_out <= '1;
                    ready   <= 1'b0;
                    stage   <= '0;
                end
            endcase
        end
    end

endmodule
